sine_dds_gen: RTL and testbench
===============================

# sine_dds_gen

Direct-digital-synthesis sine source for the sine-wave project. It drives 8-bit offset-binary samples into the DAC stage's `I_data` input on the shared `clk`. It holds a phase accumulator, a folded quarter-wave amplitude ROM and a two-stage lookup pipeline. Frequency changes are handshaked and applied only at phase wrap, so the output stays phase-continuous.

## Interface
- `PHASE_W`, 16: phase accumulator and tuning-word width (≥ `LUT_AW`+2).
- `LUT_AW`, 6: quarter-wave ROM address width (2^`LUT_AW` entries).
- `FCW_RST`, 16'h0400: tuning word loaded at reset.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: run enable; the accumulator advances only while `en`=1.
- `phase_clr` in 1: synchronous phase clear; takes priority over the advance.
- `fcw_i` in `PHASE_W`: new frequency control word.
- `fcw_valid` in 1: `fcw_i` is offered.
- `fcw_ready` out 1: a word can be accepted.
- `data_o` out 8: sample, offset binary, mid-scale 128; connects to the DAC `I_data`.
- `data_valid` out 1: `data_o` holds a new sample this cycle.

## Operation
- **Reset values:** phase 0, `fcw`=`FCW_RST`, pending flag 0, `fcw_ready`=1, pipeline valids 0, `data_o`=8'd128, `data_valid`=0.
- **Control states.** States are derived from `en` and the pending flag:
  - **IDLE**: `en`=0.
  - **RUN**: `en`=1, nothing pending.
  - **RUN_PEND**: `en`=1, a word is waiting.
- **Accumulator.** With `en`=1: `{carry, phase}` ← `phase` + `fcw`, modulo 2^`PHASE_W`. A `phase_clr` in the same cycle forces `phase` ← 0, with carry treated as 1.
- **Handshake.**
  - A word is accepted when `fcw_valid` && `fcw_ready`. `fcw_ready` = !pending.
  - Accepted in IDLE: `fcw` ← `fcw_i` at the next edge. No pending flag is set.
  - Accepted in RUN: the word goes into `fcw_pend`, pending is set, and the state moves to RUN_PEND.
- **Frequency switch at wrap.** In RUN_PEND, on the first advancing cycle with carry=1:
  - `fcw` ← `fcw_pend` and pending clears.
  - The new word is used from the following advance.
- **Accept coinciding with a wrap.** A word accepted in the same cycle as a wrap waits for the next wrap.
- **`en` falling while pending.** `fcw` ← `fcw_pend` at that edge and pending clears.
- **Pipeline stage 1** (registered):
  - `q` = `phase[PHASE_W-1:PHASE_W-2]`.
  - `idx` = the next `LUT_AW` bits, replaced by ~`idx` when `q[0]`=1.
  - `v1` = `en`.
- **Pipeline stage 2** (registered):
  - `amp` = ROM[`idx`], 7 bits.
  - `data_o` ← `q[1]` ? 128−`amp` : 128+`amp`. The result range is 1..255; no saturation is needed.
  - `data_valid` ← `v1`.
- **ROM contents:** ROM[k] = round(127·sin(π/2·(k+0.5)/2^`LUT_AW`)). For `LUT_AW`=6: ROM[0]=2, ROM[63]=127.
- When `data_valid`=0, `data_o` holds its last value.

## Timing
- **Latency:** a phase value registered at edge n appears on `data_o` at edge n+2, with `data_valid` high.
- **Throughput:** one sample per cycle while `en`=1.
- **`en` rising:** the first `data_valid` comes 2 cycles after `en` rises. The first sample uses the current phase, not the incremented one.
- **`en` falling:** `data_valid` falls 2 cycles after `en` falls. The pipeline drains and is not flushed.
- **`fcw_ready`:**
  - Drops the cycle after an accept in RUN.
  - Rises the cycle after the wrap that applies the pending word.
- **Reset mid-operation:** all state returns to reset values immediately. The pending word is discarded. The pipeline flushes and `data_valid` is 0 while `rst`=1.
- **`phase_clr`:** the cleared phase yields sample ROM[0]+128 = 130 two cycles later. A pending word is applied on that edge.

## Structure
- **Package `sine_pkg`:**
  - `PHASE_W`/`LUT_AW` defaults.
  - `MID_SCALE`=128.
  - A function that builds the quarter-wave table for elaboration-time ROM init.
  - Typedef `phase_t`.
- **Sub-module `sine_quarter_rom`:** a combinational `LUT_AW`→7-bit table. The stage-2 register stays in `sine_dds_gen`.
- **Top (`sine_dds_gen`):**
  - Accumulator.
  - Pending-word register and control.
  - Two-stage fold and output pipeline.
- Expected size: about 200 lines total.

## Test plan
- **Reset and default run.** Reset, then `en`=1 with `FCW_RST`=0x0400. Expect:
  - first valid `data_o`=130;
  - sample 16 = 255;
  - sample 32 = 126;
  - sample 48 = 1;
  - period 64 samples, with `data_valid` exactly 2 cycles after `en`.
- **Phase-continuous switch.** Offer 0x0800 at sample 10 of the default run. Expect:
  - `fcw_ready` low until the wrap at sample 64;
  - samples 0..63 unchanged;
  - from the wrap on, a period of 32 and a peak 255 at sample 8 after the wrap.
- **Accept in IDLE.** With `en`=0, offer 0x1000. Expect:
  - `fcw_ready` stays 1;
  - after `en`=1, a 16-sample period: 130, …, 255 at sample 4.
- **`phase_clr` mid-run.** Assert `phase_clr` at phase 0x2300. Expect `data_o`=130 two cycles later and the sequence restarting from phase 0.
- **Asynchronous reset mid-run.** Assert `rst` between edges while pending and running. Expect:
  - `data_o`=128, `data_valid`=0, `fcw_ready`=1 immediately;
  - the pending word is lost, and the frequency is 0x0400 after release.
- **Stop and drain.** Deassert `en` mid-period. Expect:
  - exactly 2 further valid samples;
  - `data_o` frozen afterwards;
  - on re-enable, continuation from the held phase.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared constants, types and the elaboration-time quarter-wave table builder
// for the DDS sine source.
package sine_pkg;

  localparam int unsigned PHASE_W_DEF = 16;
  localparam int unsigned LUT_AW_DEF  = 6;
  localparam logic [7:0]  MID_SCALE   = 8'd128;

  typedef logic [PHASE_W_DEF-1:0] phase_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_RUN_PEND = 2'd2
  } ctrl_state_e;

  // round(127*sin(pi/2*(k+0.5)/2^aw)); Taylor series keeps this a pure
  // constant function usable for ROM initialisation.
  function automatic logic [6:0] quarter_sine(input int unsigned k, input int unsigned aw);
    real x;
    real term;
    real acc;
    x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(32'd1 << aw);
    acc  = x;
    term = x;
    for (int unsigned n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return 7'($rtoi(127.0 * acc + 0.5));
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational quarter-wave amplitude table, 2^LUT_AW entries of 7 bits.
module sine_quarter_rom
  import sine_pkg::*;
#(
  parameter int unsigned LUT_AW = LUT_AW_DEF
) (
  input  logic [LUT_AW-1:0] idx,
  output logic [6:0]        amp
);

  logic [6:0] rom_q [2**LUT_AW];

  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    assign rom_q[k] = quarter_sine(k, LUT_AW);
  end

  assign amp = rom_q[idx];

endmodule

// File: rtl/sine_dds_gen.sv
// DDS sine source: phase accumulator with wrap-synchronised frequency switch,
// quarter-wave fold and two-stage lookup pipeline producing offset-binary samples.
module sine_dds_gen
  import sine_pkg::*;
#(
  parameter int unsigned       PHASE_W = PHASE_W_DEF,
  parameter int unsigned       LUT_AW  = LUT_AW_DEF,
  parameter logic [PHASE_W-1:0] FCW_RST = 16'h0400
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] fcw_i,
  input  logic               fcw_valid,
  output logic               fcw_ready,
  output logic [7:0]         data_o,
  output logic               data_valid
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] fcw;
  logic [PHASE_W-1:0] fcw_pend;
  logic               pending;
  logic [PHASE_W:0]   sum;
  logic               wrap;
  logic               accept;
  ctrl_state_e        state;

  logic [1:0]         q1;
  logic [LUT_AW-1:0]  idx_raw;
  logic [LUT_AW-1:0]  idx1;
  logic               v1;
  logic [6:0]         amp;

  always_comb begin
    sum     = {1'b0, phase} + {1'b0, fcw};
    // phase_clr counts as a wrap so a pending word lands on the cleared phase
    wrap    = en && (phase_clr || sum[PHASE_W]);
    accept  = fcw_valid && !pending;
    idx_raw = phase[PHASE_W-3 -: LUT_AW];
    if (!en)          state = ST_IDLE;
    else if (pending) state = ST_RUN_PEND;
    else              state = ST_RUN;
  end

  assign fcw_ready = !pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            phase <= '0;
    else if (phase_clr) phase <= '0;
    else if (en)        phase <= sum[PHASE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcw      <= FCW_RST;
      fcw_pend <= '0;
      pending  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // en dropped with a word waiting: no wrap will come, take it now
          if (pending) begin
            fcw     <= fcw_pend;
            pending <= 1'b0;
          end else if (accept) begin
            fcw <= fcw_i;
          end
        end
        ST_RUN: begin
          if (accept) begin
            fcw_pend <= fcw_i;
            pending  <= 1'b1;
          end
        end
        ST_RUN_PEND: begin
          if (wrap) begin
            fcw     <= fcw_pend;
            pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1   <= '0;
      idx1 <= '0;
      v1   <= 1'b0;
    end else begin
      q1   <= phase[PHASE_W-1 -: 2];
      idx1 <= phase[PHASE_W-2] ? ~idx_raw : idx_raw;
      v1   <= en;
    end
  end

  sine_quarter_rom #(
    .LUT_AW(LUT_AW)
  ) u_rom (
    .idx(idx1),
    .amp(amp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o     <= MID_SCALE;
      data_valid <= 1'b0;
    end else begin
      data_valid <= v1;
      if (v1) data_o <= q1[1] ? (MID_SCALE - {1'b0, amp}) : (MID_SCALE + {1'b0, amp});
    end
  end

endmodule

// File: tb/tb_sine_dds_gen.sv
// Scoreboard bench for sine_dds_gen: a transaction-level model predicts each
// sample and its due cycle; a negedge monitor pops and compares.
module tb_sine_dds_gen;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        phase_clr = 1'b0;
  logic        fcw_valid = 1'b0;
  logic [15:0] fcw_i = '0;
  logic        fcw_ready;
  logic [7:0]  data_o;
  logic        data_valid;

  sine_dds_gen #(
    .PHASE_W(16),
    .LUT_AW (6),
    .FCW_RST(16'h0400)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .phase_clr (phase_clr),
    .fcw_i     (fcw_i),
    .fcw_valid (fcw_valid),
    .fcw_ready (fcw_ready),
    .data_o    (data_o),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     val;
    longint due;
  } exp_t;

  exp_t        sb[$];
  int          got[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  longint      cyc = 0;
  int          last_out = 128;
  int          m_pushed = 0;
  int unsigned m_phase, m_fcw, m_pend;
  bit          m_pending;
  bit          mon_has;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Sample for a phase: sign from the half-cycle, magnitude from the sine
  // evaluated at the centre of the 256-step coarse phase bin.
  function automatic int exp_sample(int unsigned p);
    int  m;
    real s;
    int  mag;
    m   = int'(p >> 8);
    s   = $sin(2.0 * PI * (real'(m) + 0.5) / 256.0);
    if (s < 0.0) s = -s;
    mag = $rtoi(127.0 * s + 0.5);
    return (m < 128) ? 128 + mag : 128 - mag;
  endfunction

  function automatic void reset_model();
    m_phase   = 0;
    m_fcw     = 32'h0400;
    m_pend    = 0;
    m_pending = 0;
    sb.delete();
  endfunction

  function automatic void clear_log();
    got.delete();
    m_pushed = 0;
  endfunction

  task automatic cycle();
    bit          e, c, v, accept, wrap;
    int unsigned w;
    e = en; c = phase_clr; v = fcw_valid; w = 32'(fcw_i);
    @(posedge clk);
    #1;
    accept = v && !m_pending;
    if (e) begin
      sb.push_back('{exp_sample(m_phase), cyc + 1});
      m_pushed++;
    end
    wrap = e && (c || (m_phase + m_fcw >= 32'h10000));
    if (c)      m_phase = 0;
    else if (e) m_phase = (m_phase + m_fcw) & 32'hFFFF;
    if (!e) begin
      if (m_pending) begin m_fcw = m_pend; m_pending = 0; end
      else if (accept) m_fcw = w;
    end else if (m_pending) begin
      if (wrap) begin m_fcw = m_pend; m_pending = 0; end
    end else if (accept) begin
      m_pend = w; m_pending = 1;
    end
    chk("fcw_ready", 32'(fcw_ready), 32'(!m_pending));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic void chk_got(string nm, int i, int exp);
    chk(nm, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp));
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("valid_in_reset", 32'(data_valid), 0);
      last_out = 128;
    end else begin
      mon_has = (sb.size() > 0) && (sb[0].due == cyc);
      if (data_valid) begin
        if (!mon_has) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("sample", 32'(data_o), 32'(sb[0].val));
          void'(sb.pop_front());
        end
        got.push_back(int'(data_o));
        last_out = int'(data_o);
      end else begin
        if (mon_has) begin
          chk("missing_valid", 0, 1);
          void'(sb.pop_front());
        end
        chk("hold_data", 32'(data_o), 32'(last_out));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int idx;
    bit found;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_o", 32'(data_o), 128);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_fcw_ready", 32'(fcw_ready), 1);
    reset_model();
    rst = 1'b0;

    // Default run with a word offered at sample 10, switching at the wrap.
    clear_log();
    en = 1'b1;
    for (int i = 0; i < 110; i++) begin
      fcw_valid = (i == 10);
      fcw_i     = 16'h0800;
      cycle();
    end
    fcw_valid = 1'b0;
    chk_got("first_sample", 0, 130);
    chk_got("sample16", 16, 255);
    chk_got("sample32", 32, 126);
    chk_got("sample48", 48, 1);
    chk_got("wrap_sample64", 64, 130);
    chk_got("fast_peak72", 72, 255);
    chk_got("fast_peak104", 104, 255);

    // Stop mid-period: two more samples drain, output then frozen.
    en = 1'b0;
    n0 = got.size();
    run(6);
    chk("drain_count", 32'(got.size() - n0), 2);
    en = 1'b1;
    run(20);
    en = 1'b0;
    run(4);

    // Asynchronous reset while running with a word pending.
    en = 1'b1;
    phase_clr = 1'b1;
    cycle();
    phase_clr = 1'b0;
    run(4);
    fcw_valid = 1'b1;
    fcw_i     = 16'h2000;
    cycle();
    fcw_valid = 1'b0;
    run(3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data_o", 32'(data_o), 128);
    chk("arst_data_valid", 32'(data_valid), 0);
    chk("arst_fcw_ready", 32'(fcw_ready), 1);
    reset_model();
    clear_log();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(84);
    chk_got("post_rst_first", 0, 130);
    chk_got("post_rst_peak16", 16, 255);
    chk_got("post_rst_peak80", 80, 255);
    en = 1'b0;
    run(4);

    // Accept while idle: immediate, no pending.
    rst = 1'b1;
    reset_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    fcw_valid = 1'b1;
    fcw_i     = 16'h1000;
    cycle();
    fcw_valid = 1'b0;
    run(2);
    clear_log();
    en = 1'b1;
    run(40);
    chk_got("idle_first", 0, 130);
    chk_got("idle_peak4", 4, 255);
    chk_got("idle_peak20", 20, 255);
    en = 1'b0;
    run(4);

    // phase_clr at phase 0x2300.
    fcw_valid = 1'b1;
    fcw_i     = 16'h0100;
    cycle();
    fcw_valid = 1'b0;
    clear_log();
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_phase == 32'h2300) found = 1'b1;
      else cycle();
    end
    chk("reach_phase_2300", 32'(found), 1);
    idx = m_pushed;
    phase_clr = 1'b1;
    cycle();
    phase_clr = 1'b0;
    run(10);
    chk_got("clr_sample", idx + 1, 130);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      phase_clr = en && ($urandom_range(0, 49) == 0);
      fcw_valid = ($urandom_range(0, 7) == 0);
      fcw_i     = 16'($urandom_range(16'h0200, 16'h3000));
      cycle();
    end
    en = 1'b0;
    phase_clr = 1'b0;
    fcw_valid = 1'b0;
    run(4);
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
